// File: rtl/mor1kx_branch_predictor_counter_table.sv
// mor1kx_branch_predictor_counter_table: saturating-counter branch predictor (bimodal or gshare) with init sweep
module mor1kx_branch_predictor_counter_table #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int INDEX_WIDTH = 6,
  parameter int COUNTER_WIDTH = 2,
  parameter int HISTORY_WIDTH = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_decode_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pc_decode_i,
  input  logic                            op_bf_i,
  input  logic                            op_bnf_i,
  input  logic [9:0]                      immjbr_upper_i,
  output logic                            predicted_flag_o,
  input  logic                            padv_execute_i,
  input  logic                            execute_op_bf_i,
  input  logic                            execute_op_bnf_i,
  input  logic                            flag_i,
  output logic                            ready_o
);
  localparam int GW = HISTORY_WIDTH > 0 ? HISTORY_WIDTH : 1;
  localparam int N = 1 << INDEX_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] CINIT = COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);
  localparam logic [COUNTER_WIDTH-1:0] CMAX = '1;
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [INDEX_WIDTH-1:0] ptr, idx, exec_idx_r, ghr_x, wr_idx;
  logic [GW-1:0] ghr, ghr_n;
  logic [COUNTER_WIDTH-1:0] mem [N];
  logic [COUNTER_WIDTH-1:0] rd, cur, upd_val, wr_val;
  logic taken, upd, wr_en, taken_pred, unused;
  assign unused = ^{pc_decode_i, immjbr_upper_i[8:0]};
  assign ghr_x = HISTORY_WIDTH > 0 ? INDEX_WIDTH'(ghr) : '0;
  assign idx = pc_decode_i[INDEX_WIDTH+1:2] ^ ghr_x;
  assign rd = mem[idx];
  assign taken_pred = rd[COUNTER_WIDTH-1];
  assign predicted_flag_o = ready_o ? (op_bf_i ? taken_pred : op_bnf_i & !taken_pred)
                                    : (op_bf_i & immjbr_upper_i[9]) | (op_bnf_i & !immjbr_upper_i[9]);
  assign taken = execute_op_bf_i ? flag_i : !flag_i;
  assign upd = (state == RUN) & padv_execute_i & (execute_op_bf_i | execute_op_bnf_i);
  assign cur = mem[exec_idx_r];
  assign upd_val = taken ? (cur == CMAX ? cur : cur + 1'b1) : (cur == '0 ? cur : cur - 1'b1);
  assign wr_en = (state == INIT) | upd;
  assign wr_idx = state == INIT ? ptr : exec_idx_r;
  assign wr_val = state == INIT ? CINIT : upd_val;
  assign ghr_n = (ghr << 1) | GW'(taken);
  // Single table write port: init sweep or training update; no reset, the sweep initialises it
  always_ff @(posedge clk)
    if (wr_en) mem[wr_idx] <= wr_val;
  // Sweep sequencing, history shift and decode-to-execute index latch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INIT;
      ptr <= '0;
      ghr <= '0;
      exec_idx_r <= '0;
      ready_o <= 1'b0;
    end else begin
      if (state == INIT) begin
        ptr <= ptr + 1'b1;
        if (ptr == '1) begin
          state <= RUN;
          ready_o <= 1'b1;
        end
      end
      if (upd && HISTORY_WIDTH > 0) ghr <= ghr_n;
      if (padv_decode_i & (op_bf_i | op_bnf_i)) exec_idx_r <= idx;
    end
endmodule

// File: tb/tb_mor1kx_branch_predictor_counter_table.sv
// tb_mor1kx_branch_predictor_counter_table: bimodal and gshare instances checked against a counter-array model
module tb_mor1kx_branch_predictor_counter_table;
  logic clk = 0, rst = 1, pd = 0, bf = 0, bnf = 0, pe = 0, ebf = 0, ebnf = 0, fl = 0;
  logic [31:0] pc = 0;
  logic [9:0] imm = 0;
  logic p0, r0, p2, r2;
  int checks = 0, errors = 0;
  int m0[16], m2[16];
  int g2 = 0, e0 = 0, e2 = 0, mptr = 0;
  bit mrdy = 0;
  always #5 clk = ~clk;
  mor1kx_branch_predictor_counter_table #(.OPTION_OPERAND_WIDTH(32), .INDEX_WIDTH(4), .COUNTER_WIDTH(2), .HISTORY_WIDTH(0)) dut0 (
    .clk(clk), .rst(rst), .padv_decode_i(pd), .pc_decode_i(pc), .op_bf_i(bf), .op_bnf_i(bnf),
    .immjbr_upper_i(imm), .predicted_flag_o(p0), .padv_execute_i(pe), .execute_op_bf_i(ebf),
    .execute_op_bnf_i(ebnf), .flag_i(fl), .ready_o(r0));
  mor1kx_branch_predictor_counter_table #(.OPTION_OPERAND_WIDTH(32), .INDEX_WIDTH(4), .COUNTER_WIDTH(2), .HISTORY_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .padv_decode_i(pd), .pc_decode_i(pc), .op_bf_i(bf), .op_bnf_i(bnf),
    .immjbr_upper_i(imm), .predicted_flag_o(p2), .padv_execute_i(pe), .execute_op_bf_i(ebf),
    .execute_op_bnf_i(ebnf), .flag_i(fl), .ready_o(r2));
  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit pred(bit rdy, int c, bit b, bit n, bit s);
    if (!rdy) return (b & s) | (n & !s);
    return b ? (c >= 2) : (n && c < 2);
  endfunction
  function automatic int sat(int c, bit up);
    return up ? (c < 3 ? c + 1 : 3) : (c > 0 ? c - 1 : 0);
  endfunction
  task automatic step(input bit d, input logic [31:0] a, input bit b, input bit n, input logic [9:0] im,
                      input bit e, input bit eb, input bit en, input bit f);
    int i0, i2;
    bit tk;
    pd = d; pc = a; bf = b; bnf = n; imm = im; pe = e; ebf = eb; ebnf = en; fl = f;
    if (rst) begin
      mptr = 0; mrdy = 0; g2 = 0; e0 = 0; e2 = 0;
    end
    i0 = int'(a[5:2]);
    i2 = i0 ^ g2;
    #1;
    check("ready0", r0, mrdy);
    check("ready2", r2, mrdy);
    check("pred0", p0, pred(mrdy, m0[i0], b, n, im[9]));
    check("pred2", p2, pred(mrdy, m2[i2], b, n, im[9]));
    @(posedge clk);
    if (!rst) begin
      if (!mrdy) begin
        m0[mptr] = 1; m2[mptr] = 1; mptr++;
        mrdy = (mptr == 16);
      end else if (e && (eb || en)) begin
        tk = eb ? f : !f;
        m0[e0] = sat(m0[e0], tk);
        m2[e2] = sat(m2[e2], tk);
        g2 = ((g2 << 1) | int'(tk)) & 3;
      end
      if (d && (b || n)) begin
        e0 = i0; e2 = i2;
      end
    end
    @(negedge clk);
  endtask
  task automatic dec(input logic [31:0] a, input bit b);
    step(1'b1, a, b, !b, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic res(input bit b, input bit f);
    step(1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 1'b1, b, !b, f);
  endtask
  task automatic rnd(input bit force_upd);
    bit b, n, eb;
    b = 1'($urandom);
    n = !b && ($urandom % 4 != 0);
    eb = 1'($urandom);
    step(1'($urandom), $urandom, b, n, 10'($urandom), force_upd | 1'($urandom), eb, !eb, 1'($urandom));
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    repeat (2) step(1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 0;
    step(1'b1, 32'h200, 1'b1, 1'b0, 10'h200, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h204, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h208, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h20c, 1'b0, 1'b1, 10'h200, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (12) rnd(1'b0);
    check("ready_after_init", r0, 1'b1);
    dec(32'h100, 1'b1); res(1'b1, 1'b1); res(1'b1, 1'b1);
    dec(32'h100, 1'b1); res(1'b1, 1'b1); dec(32'h100, 1'b1);
    dec(32'h104, 1'b0); res(1'b0, 1'b0); res(1'b0, 1'b0);
    dec(32'h104, 1'b0); res(1'b0, 1'b1); res(1'b0, 1'b1); res(1'b0, 1'b1); dec(32'h104, 1'b0);
    dec(32'h14, 1'b1);
    step(1'b1, 32'h14, 1'b1, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    dec(32'h14, 1'b1);
    for (int i = 0; i < 16; i++) begin
      pd = 0; pc = 32'h40; bf = 1; bnf = 0; pe = 0;
      #1;
      if (i >= 8) check("alt_match", p2, 1'(i % 2 == 0));
      dec(32'h40, 1'b1);
      res(1'b1, 1'(i % 2 == 0));
    end
    repeat (300) rnd(1'b0);
    rst = 1;
    step(1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 0;
    repeat (7) rnd(1'b0);
    rst = 1;
    #1;
    check("mid_rst_ready", r0, 1'b0);
    rnd(1'b1);
    rst = 0;
    repeat (16) rnd(1'b1);
    for (int j = 0; j < 16; j++) begin
      pd = 0; pe = 0; pc = 32'(j << 2); bf = 1; bnf = 0;
      #1;
      check("init_bf0", p0, 1'b0);
      check("init_bf2", p2, 1'b0);
      bf = 0; bnf = 1;
      #1;
      check("init_bnf0", p0, 1'b1);
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
